// File: rtl/ei_axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory: burst encodings, response codes,
// FSM states and the per-burst beat configuration captured by the address generators.
package ei_axi4_slave_pkg;

  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } beat_cfg_t;

  function automatic logic [7:0] beat_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// Per-channel beat address generator. addr_o is the address of the beat being
// handled this cycle (the start address in the load cycle); err_o flags the whole burst.
module ei_axi4_addr_gen
  import ei_axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [ADDR_WIDTH-1:0] start_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  err_o
);
  localparam int XW = ADDR_WIDTH + 16;
  localparam int LG = $clog2(DATA_WIDTH / 8);
  localparam logic [XW-1:0] MEM_BYTES = XW'(MEM_DEPTH * (DATA_WIDTH / 8));

  beat_cfg_t             cfg_q, cfg;
  logic [ADDR_WIDTH-1:0] start_q, st, addr_q, nxt_d, amask;
  logic [XW-1:0]         sx, bytes, wsize, last;

  always_comb begin
    cfg = cfg_q;
    st  = start_q;
    if (load_i) begin
      cfg.len   = len_i;
      cfg.size  = size_i;
      cfg.burst = burst_i;
      st        = start_i;
    end
    addr_o = load_i ? start_i : addr_q;
    sx     = XW'(st);
    bytes  = XW'(beat_bytes(cfg.size));
    wsize  = (XW'(cfg.len) + XW'(1)) << cfg.size;
    amask  = ADDR_WIDTH'(wsize - XW'(1));
    last   = sx;
    nxt_d  = addr_o;
    // Highest byte the burst can touch; the memory window is checked once per burst.
    case (cfg.burst)
      INCR: begin
        last  = sx + (XW'(cfg.len) << cfg.size);
        nxt_d = addr_o + ADDR_WIDTH'(bytes);
      end
      WRAP: begin
        last  = (sx & ~(wsize - XW'(1))) + wsize - XW'(1);
        nxt_d = (addr_o & ~amask) | ((addr_o + ADDR_WIDTH'(bytes)) & amask);
      end
      default: ;
    endcase
    err_o = (cfg.size > 3'(LG)) || (cfg.burst == 2'b11) || (last >= MEM_BYTES) ||
            ((cfg.burst == WRAP) &&
             (!(cfg.len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((sx & (bytes - XW'(1))) != '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      start_q <= '0;
      cfg_q   <= '0;
    end else begin
      addr_q <= adv_i ? nxt_d : addr_o;
      if (load_i) begin
        start_q <= start_i;
        cfg_q   <= cfg;
      end
    end
  end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: independent single-outstanding write and read FSMs over a
// byte-strobed word RAM, with registered outputs and deterministic latency.
module ei_axi4_slave_mem
  import ei_axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LG = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);

  wstate_e w_state_q, w_state_d;
  rstate_e r_state_q, r_state_d;
  logic                  rdy_q;
  logic [8:0]            wcnt_q;
  logic [7:0]            wlen_q, rlen_q, rcnt_q;
  logic [ID_WIDTH-1:0]   bid_q, rid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rlast_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  aw_hs, w_hs, ar_hs, r_hs, r_fetch, wr_en, werr, rerr;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [IW-1:0]         widx, ridx;

  // rdy_q holds the address channels off until the first clock after reset release.
  assign awready = rdy_q && (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign arready = rdy_q && (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  // Next read beat is fetched into the output register as the current one is taken.
  assign r_fetch = ar_hs || (r_hs && !rlast_q);
  assign wr_en   = w_hs && !werr && (wcnt_q <= {1'b0, wlen_q});
  assign widx    = IW'(waddr >> LG);
  assign ridx    = IW'(raddr >> LG);

  ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
    .clk(aclk), .rst_n(aresetn), .load_i(aw_hs), .adv_i(w_hs), .start_i(awaddr),
    .len_i(awlen), .size_i(awsize), .burst_i(awburst), .addr_o(waddr), .err_o(werr)
  );

  ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
    .clk(aclk), .rst_n(aresetn), .load_i(ar_hs), .adv_i(r_fetch), .start_i(araddr),
    .len_i(arlen), .size_i(arsize), .burst_i(arburst), .addr_o(raddr), .err_o(rerr)
  );

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && wlast) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdy_q     <= 1'b0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_q     <= 1'b1;
      if (aw_hs) begin
        bid_q  <= awid;
        wlen_q <= awlen;
        wcnt_q <= '0;
      end else if (w_hs && wcnt_q != '1) begin
        wcnt_q <= wcnt_q + 9'd1;
      end
      if (w_hs && wlast)
        bresp_q <= (werr || wcnt_q != {1'b0, wlen_q}) ? SLVERR : OKAY;
      if (ar_hs) begin
        rid_q  <= arid;
        rlen_q <= arlen;
      end
      if (r_fetch) begin
        rcnt_q  <= ar_hs ? 8'd0 : rcnt_q + 8'd1;
        rlast_q <= ar_hs ? (arlen == 8'd0) : (rcnt_q + 8'd1 == rlen_q);
        rdata_q <= rerr ? '0 : mem_q[ridx];
        rresp_q <= rerr ? SLVERR : OKAY;
      end else if (r_hs) begin
        rlast_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem: burst types, strobes, error responses,
// backpressure and reset during a read, all against hand-computed values.
module tb_ei_axi4_slave_mem;
  logic        aclk, aresetn;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          nrd;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;

  localparam logic [1:0] BF = 2'd0, BI = 2'd1, BW = 2'd2;

  ei_axi4_slave_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] id, input int nb, input int bhold);
    int n;
    bready  = (bhold == 0);
    awaddr  = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
    chk("aw_ready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nb - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(posedge aclk); #1; n++; end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    chk("b_valid", bvalid, 1);
    for (int i = 0; i < bhold; i++) begin
      chk("b_hold_bvalid", bvalid, 1);
      chk("b_hold_awready", awready, 0);
      @(posedge aclk); #1;
    end
    bready  = 1'b1;
    wr_resp = bresp;
    wr_id   = bid;
    @(posedge aclk); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] id, input bit toggle);
    int n, cyc;
    logic [31:0] held;
    bit hold;
    araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
    chk("ar_ready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready  = !toggle;
    nrd = 0; cyc = 0; hold = 1'b0; held = '0;
    while (nrd <= int'(len) && cyc < 200) begin
      if (rvalid && rready) begin
        rd_data[nrd] = rdata; rd_resp[nrd] = rresp; rd_last[nrd] = rlast; rd_id[nrd] = rid;
        nrd++;
      end else if (rvalid) begin
        held = rdata; hold = 1'b1;
      end
      @(posedge aclk); #1;
      cyc++;
      if (hold) begin chk("r_stable", rdata, held); hold = 1'b0; end
      if (toggle) rready = !rready;
    end
    chk("r_beats", nrd, int'(len) + 1);
    rready = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    chk("rel_awready_low", awready, 0);
    @(posedge aclk); #1;
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    // INCR write then read
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    wr(32'h10, 8'd3, BI, 4'h3, 4, 0);
    chk("incr_bresp", wr_resp, 2'b00);
    chk("incr_bid", wr_id, 4'h3);
    rd(32'h10, 8'd3, BI, 4'h5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd_data[i], 32'hA0 + 32'(i));
      chk("incr_rlast", rd_last[i], (i == 3));
      chk("incr_rresp", rd_resp[i], 2'b00);
    end
    chk("incr_rid", rd_id[0], 4'h5);

    // WRAP write at 0x18 lands on 0x18, 0x1C, 0x10, 0x14
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
    wr(32'h18, 8'd3, BW, 4'h1, 4, 0);
    chk("wrap_bresp", wr_resp, 2'b00);
    rd(32'h10, 8'd3, BI, 4'h2, 1'b0);
    chk("wrap_rd0", rd_data[0], 32'hB2);
    chk("wrap_rd1", rd_data[1], 32'hB3);
    chk("wrap_rd2", rd_data[2], 32'hB0);
    chk("wrap_rd3", rd_data[3], 32'hB1);

    // FIXED with byte strobes onto a cleared word
    wbuf[0] = 32'h0; sbuf[0] = 4'hF;
    wr(32'h40, 8'd0, BI, 4'h0, 1, 0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0011;
    wbuf[1] = 32'h55667788; sbuf[1] = 4'b1100;
    wr(32'h40, 8'd1, BF, 4'h7, 2, 0);
    chk("fixed_bresp", wr_resp, 2'b00);
    rd(32'h40, 8'd0, BI, 4'h0, 1'b0);
    chk("fixed_rdata", rd_data[0], 32'h55663344);
    chk("fixed_rlast", rd_last[0], 1);

    // Out-of-range write must not alias onto word 0
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    wr(32'h0, 8'd0, BI, 4'h0, 1, 0);
    wbuf[0] = 32'hDEADBEEF;
    wr(32'h1000, 8'd0, BI, 4'h9, 1, 0);
    chk("oob_bresp", wr_resp, 2'b10);
    chk("oob_bid", wr_id, 4'h9);
    rd(32'h0, 8'd0, BI, 4'h0, 1'b0);
    chk("oob_nochange", rd_data[0], 32'h12345678);
    rd(32'h1000, 8'd0, BI, 4'h4, 1'b0);
    chk("oob_rresp", rd_resp[0], 2'b10);
    chk("oob_rdata", rd_data[0], 32'h0);

    // WRAP with illegal length: SLVERR and no write
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
    wr(32'h10, 8'd2, BW, 4'h2, 3, 0);
    chk("wrap_len2_bresp", wr_resp, 2'b10);
    rd(32'h10, 8'd0, BI, 4'h0, 1'b0);
    chk("wrap_len2_nowrite", rd_data[0], 32'hB2);

    // Early wlast on beat 1 of a 4-beat burst
    wr(32'h60, 8'd3, BI, 4'h6, 2, 0);
    chk("early_wlast_bresp", wr_resp, 2'b10);

    // B backpressure
    wbuf[0] = 32'h77; sbuf[0] = 4'hF;
    wr(32'h50, 8'd0, BI, 4'hA, 1, 5);
    chk("bp_bresp", wr_resp, 2'b00);
    chk("bp_bid", wr_id, 4'hA);
    chk("bp_awready_after", awready, 1);

    // R backpressure, rready toggling every cycle
    rd(32'h10, 8'd3, BI, 4'hB, 1'b1);
    chk("tog_rd0", rd_data[0], 32'hB2);
    chk("tog_rd1", rd_data[1], 32'hB3);
    chk("tog_rd2", rd_data[2], 32'hB0);
    chk("tog_rd3", rd_data[3], 32'hB1);
    chk("tog_rlast3", rd_last[3], 1);

    // Reset while beat 2 is presented
    araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = BI; arid = 4'h1; arvalid = 1'b1;
    chk("mid_ar_ready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("mid_pre_rvalid", rvalid, 1);
    chk("mid_pre_rdata", rdata, 32'hB0);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rvalid_drop", rvalid, 0);
    chk("mid_arready_drop", arready, 0);
    chk("mid_awready_drop", awready, 0);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("mid_arready_back", arready, 1);
    rd(32'h40, 8'd0, BI, 4'h0, 1'b0);
    chk("mid_after_rd40", rd_data[0], 32'h55663344);
    rd(32'h0, 8'd0, BI, 4'h0, 1'b0);
    chk("mid_after_rd0", rd_data[0], 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

AXI4 slave memory responder that is the design under test the VIP master drives through `ei_axi4_interface`. It accepts single-outstanding write and read bursts (FIXED, INCR, WRAP), stores data in an internal word-addressed RAM with byte strobes, and returns B and R responses. It exists so the VIP's master-side tests have a synthesizable, protocol-correct consumer with deterministic latency.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; legal values 32 or 64
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, number of DATA_WIDTH words

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous assert, active-low
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID_WIDTH/2  write response; bvalid out 1, bready in 1
- arid/araddr/arlen/arsize/arburst  in  as AW  read address
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data; rvalid out 1, rready in 1

## Operation
- Write FSM: W_IDLE -> (AW handshake) W_DATA -> (W handshake with wlast) W_RESP -> (B handshake) W_IDLE.
- Read FSM: R_IDLE -> (AR handshake) R_DATA -> (R handshake with rlast) R_IDLE.
- The two FSMs are independent; one write and one read are in flight concurrently.
- Address per beat: FIXED = start address; INCR = previous + 2^size; WRAP = increment within a window of (len+1)*2^size bytes aligned to that size, wrapping to the window base.
- Word index = addr >> log2(DATA_WIDTH/8). Only wstrb-enabled bytes are written.
- Error (SLVERR=2'b10), reported on bresp / every rresp of the burst:
  - awsize/arsize > log2(DATA_WIDTH/8)
  - any beat address at or beyond MEM_DEPTH*DATA_WIDTH/8
  - WRAP with len not in {1,3,7,15}, or WRAP start not aligned to 2^size
  - reserved burst type 2'b11
- On error, writes are dropped and read data is 0. OKAY = 2'b00. EXOKAY/DECERR are never issued.
- Write beat count: the burst ends on the wlast handshake. If the accepted beats differ from awlen+1, bresp is SLVERR. Beats past awlen+1 are not written.
- bid/rid echo the captured awid/arid.
- Same-cycle read and write to the same word: the read returns the pre-write value.

## Timing
- Reset values: awready=arready=wready=bvalid=rvalid=rlast=0; bid, bresp, rid, rresp and rdata are 0. RAM contents are not reset.
- awready and arready rise the first cycle after aresetn deasserts, and stay high in IDLE.
- AW handshake at cycle N: awready=0 and wready=1 from N+1. One beat is accepted per cycle while wvalid is high.
- wlast handshake at M: wready=0 and bvalid=1 at M+1. bvalid holds until bready. awready=1 the cycle after the B handshake.
- AR handshake at N: rvalid=1 with beat 0 at N+1. Beats run back-to-back while rready is high.
- rvalid, rdata, rresp and rlast are stable while rready is low.
- rlast is high on beat arlen. arready=1 the cycle after the rlast handshake.
- No combinational path from any input to any output.
- Reset mid-burst: both FSMs return to IDLE immediately and all valid/ready outputs drop asynchronously. The burst is abandoned with no response.

## Structure
- Package ei_axi4_slave_pkg holds:
  - burst enum: FIXED=0, INCR=1, WRAP=2
  - resp constants: OKAY, SLVERR
  - FSM state enums
  - function computing bytes-per-beat from size
- Sub-module ei_axi4_addr_gen, instantiated once per channel. Inputs: start address, len, size, burst, beat-advance strobe. Outputs: current address and error flag.
- RAM is a plain array in the top-level module.

## Test plan
- INCR write then read: awaddr=0x10, len=3, size=2, data 0xA0..0xA3, strobes all 1 -> bresp=OKAY; read returns 0xA0..0xA3, rlast on beat 3, rresp=OKAY.
- WRAP: after the previous test, write len=3 at 0x18 with 0xB0..0xB3 -> words written at 0x18, 0x1C, 0x10, 0x14; reading 0x10, len=3 INCR returns 0xB2, 0xB3, 0xB0, 0xB1.
- Strobe/FIXED: FIXED write to 0x40, len=1, with 0x11223344 (wstrb=4'b0011) then 0x55667788 (wstrb=4'b1100), memory initially 0 -> read 0x40 returns 0x55663344.
- Errors: write at MEM_DEPTH*4 -> bresp=SLVERR and no memory change; WRAP with len=2 -> SLVERR; early wlast on beat 1 of a len=3 burst -> SLVERR.
- Backpressure: bready held low for 5 cycles -> bvalid held and awready stays 0; rready toggled every cycle -> every beat delivered once, in order, with stable rdata.
- Reset mid-read: aresetn pulsed low on beat 2 -> rvalid drops immediately; arready=1 one cycle after release; a new read succeeds and earlier written data is intact.
